data_mem_io: RTL

- Data-side memory and memory-mapped I/O block. Sits directly downstream of the RV32I core's data port.
- Consumes the core's word Address, store data and We. Returns load data on the core's Data_in.
- Contains a 58-word data RAM, a GPIO output/input register pair and one 32-bit compare timer with a sticky interrupt flag.

---
 rtl/data_mem_io.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/data_mem_io.sv
// data_mem_io
//   Data-side memory and memory-mapped I/O behind the RV32I core data port.
//   It holds a 58-word data RAM, a GPIO output/input register pair and an
//   optional 32-bit compare timer with a sticky interrupt flag.
//
//   Build option: define DATA_MEM_TIMER_EN to implement the timer at word
//   addresses 58..60. When it is undefined, those addresses read 0, writes
//   to them are ignored, and Timer_irq is tied to 0.
//
//   Ports
//     Clk        in   system clock, rising edge
//     Reset      in   asynchronous active-low reset
//     Address    in   [5:0]  word address from the core
//     Wr_data    in   [31:0] store data
//     We         in   write enable, applied on the rising edge
//     Rd_data    out  [31:0] load data, combinational
//     Gpio_in    in   [GPIO_W-1:0] asynchronous external inputs
//     Gpio_out   out  [GPIO_W-1:0] registered GPIO outputs
//     Timer_irq  out  level interrupt, the sticky flag CTRL[2]
//
//   Address map
//     0..57 RAM, 58 TIMER_CMP, 59 TIMER_CTRL, 60 TIMER_CNT,
//     61 GPIO_OUT, 62 GPIO_IN (read-only), 63 reserved (reads 0)
module data_mem_io #(
    parameter int GPIO_W    = 8,
    parameter int RAM_WORDS = 58
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [5:0]        Address,
    input  logic [31:0]       Wr_data,
    input  logic              We,
    output logic [31:0]       Rd_data,
    input  logic [GPIO_W-1:0] Gpio_in,
    output logic [GPIO_W-1:0] Gpio_out,
    output logic              Timer_irq
);

    localparam logic [5:0] A_CMP  = 6'd58;
    localparam logic [5:0] A_CTRL = 6'd59;
    localparam logic [5:0] A_CNT  = 6'd60;
    localparam logic [5:0] A_GOUT = 6'd61;
    localparam logic [5:0] A_GIN  = 6'd62;

    // ---------------- RAM (not reset) ----------------
    logic [31:0] ram [RAM_WORDS];
    logic        ram_hit;

    assign ram_hit = (Address < 6'(RAM_WORDS));

    always_ff @(posedge Clk) begin
        if (We && ram_hit)
            ram[Address] <= Wr_data;
    end

    // ---------------- GPIO ----------------
    logic [GPIO_W-1:0] gpio_out;
    logic [GPIO_W-1:0] gpio_s1;
    logic [GPIO_W-1:0] gpio_s2;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            gpio_out <= '0;
            gpio_s1  <= '0;
            gpio_s2  <= '0;
        end else begin
            if (We && Address == A_GOUT)
                gpio_out <= Wr_data[GPIO_W-1:0];
            // Two-flop synchronizer for the asynchronous inputs
            gpio_s1 <= Gpio_in;
            gpio_s2 <= gpio_s1;
        end
    end

    assign Gpio_out = gpio_out;

    // ---------------- Timer ----------------
`ifdef DATA_MEM_TIMER_EN
    logic [31:0] tmr_cmp;
    logic [31:0] tmr_cnt;
    logic        tmr_en;
    logic        tmr_ar;
    logic        tmr_flag;
    logic        cnt_wr;
    logic        ctrl_wr;
    logic        match;

    assign cnt_wr  = We && (Address == A_CNT);
    assign ctrl_wr = We && (Address == A_CTRL);
    // The match uses the count before the edge. A CPU write to CNT
    // suppresses the match for that cycle.
    assign match   = tmr_en && !cnt_wr && (tmr_cnt == tmr_cmp);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tmr_cmp  <= '0;
            tmr_cnt  <= '0;
            tmr_en   <= 1'b0;
            tmr_ar   <= 1'b0;
            tmr_flag <= 1'b0;
        end else begin
            if (We && Address == A_CMP)
                tmr_cmp <= Wr_data;
            if (ctrl_wr) begin
                tmr_en <= Wr_data[0];
                tmr_ar <= Wr_data[1];
            end
            if (cnt_wr)
                tmr_cnt <= Wr_data;
            else if (tmr_en)
                tmr_cnt <= (match && tmr_ar) ? 32'd0 : tmr_cnt + 32'd1;
            // If a set and a write-1-clear happen in the same cycle, the set wins
            if (match)
                tmr_flag <= 1'b1;
            else if (ctrl_wr && Wr_data[2])
                tmr_flag <= 1'b0;
        end
    end

    assign Timer_irq = tmr_flag;
`else
    assign Timer_irq = 1'b0;
`endif

    // ---------------- Read mux ----------------
    always_comb begin
        Rd_data = '0;
        if (ram_hit) begin
            Rd_data = ram[Address];
        end else begin
            case (Address)
`ifdef DATA_MEM_TIMER_EN
                A_CMP:  Rd_data = tmr_cmp;
                A_CTRL: Rd_data = {29'd0, tmr_flag, tmr_ar, tmr_en};
                A_CNT:  Rd_data = tmr_cnt;
`endif
                A_GOUT: Rd_data = {{(32-GPIO_W){1'b0}}, gpio_out};
                A_GIN:  Rd_data = {{(32-GPIO_W){1'b0}}, gpio_s2};
                default: Rd_data = '0;
            endcase
        end
    end

endmodule
